// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and constants for the operand fetch stage.
// REG_PC is the select that reads the program counter instead of the register file.
package operand_fetch_stage_pkg;

    localparam int DW = 32;
    localparam int AW = 4;

    localparam logic [AW-1:0] REG_PC = 4'hF;

    typedef struct packed {
        logic valid;
        logic wr;
        logic load;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(3'b000);

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode-slot, forwarding and ALU-side signals of the operand fetch stage.
// The slave modport is the stage itself; the master modport is its environment.
interface operand_fetch_stage_if
    import operand_fetch_stage_pkg::*;
();

    logic          in_valid;
    logic [DW-1:0] PA;
    logic [DW-1:0] PB;
    logic [AW-1:0] SA;
    logic [AW-1:0] SB;
    logic          use_a;
    logic          use_b;
    logic [AW-1:0] dsel_in;
    logic          wr_in;
    logic          load_in;
    logic [DW-1:0] pc_plus8;
    logic [DW-1:0] ex_result;
    logic [DW-1:0] mem_result;
    logic [AW-1:0] ex_dest;
    logic [AW-1:0] mem_dest;
    logic          ex_wr;
    logic          mem_wr;
    logic          ex_load;
    logic          flush;

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [AW-1:0] dsel_out;
    logic          wr_out;
    logic          load_out;
    logic          out_valid;
    logic          stall_req;

    modport slave (
        input  in_valid, PA, PB, SA, SB, use_a, use_b, dsel_in, wr_in, load_in,
               pc_plus8, ex_result, mem_result, ex_dest, mem_dest, ex_wr, mem_wr,
               ex_load, flush,
        output op_a, op_b, dsel_out, wr_out, load_out, out_valid, stall_req
    );

    modport master (
        output in_valid, PA, PB, SA, SB, use_a, use_b, dsel_in, wr_in, load_in,
               pc_plus8, ex_result, mem_result, ex_dest, mem_dest, ex_wr, mem_wr,
               ex_load, flush,
        input  op_a, op_b, dsel_out, wr_out, load_out, out_valid, stall_req
    );

endinterface

// File: rtl/operand_fetch_stage_fwd_mux.sv
// One-port operand selector: PC for R15, then EX, then MEM, then register file.
// A load still in EX has no data yet, so it must not win the EX slot.
module operand_fetch_stage_fwd_mux
    import operand_fetch_stage_pkg::*;
(
    input  logic [AW-1:0] sel,
    input  logic [DW-1:0] rf_val,
    input  logic [DW-1:0] pc_plus8,
    input  logic [DW-1:0] ex_result,
    input  logic [AW-1:0] ex_dest,
    input  logic          ex_wr,
    input  logic          ex_load,
    input  logic [DW-1:0] mem_result,
    input  logic [AW-1:0] mem_dest,
    input  logic          mem_wr,
    output logic [DW-1:0] operand
);

    always_comb begin
        operand = rf_val;
        if (sel == REG_PC) begin
            operand = pc_plus8;
        end else if (ex_wr && !ex_load && (ex_dest == sel)) begin
            operand = ex_result;
        end else if (mem_wr && (mem_dest == sel)) begin
            operand = mem_result;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: forwarded operand capture, load-use stall and bubble insertion.
// flush beats a hazard, which beats a normal load of the output register.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input logic                  CLK,
    input logic                  CLR,
    operand_fetch_stage_if.slave bus
);

    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic          hazard;

    logic [DW-1:0] op_a_q;
    logic [DW-1:0] op_b_q;
    logic [AW-1:0] dsel_q;
    ctrl_t         ctrl_q;

    operand_fetch_stage_fwd_mux u_fwd_mux_a (
        .sel        (bus.SA),
        .rf_val     (bus.PA),
        .pc_plus8   (bus.pc_plus8),
        .ex_result  (bus.ex_result),
        .ex_dest    (bus.ex_dest),
        .ex_wr      (bus.ex_wr),
        .ex_load    (bus.ex_load),
        .mem_result (bus.mem_result),
        .mem_dest   (bus.mem_dest),
        .mem_wr     (bus.mem_wr),
        .operand    (sel_a)
    );

    operand_fetch_stage_fwd_mux u_fwd_mux_b (
        .sel        (bus.SB),
        .rf_val     (bus.PB),
        .pc_plus8   (bus.pc_plus8),
        .ex_result  (bus.ex_result),
        .ex_dest    (bus.ex_dest),
        .ex_wr      (bus.ex_wr),
        .ex_load    (bus.ex_load),
        .mem_result (bus.mem_result),
        .mem_dest   (bus.mem_dest),
        .mem_wr     (bus.mem_wr),
        .operand    (sel_b)
    );

    // R15 is never produced by a load in flight, so it can never cause a stall.
    always_comb begin
        hazard = bus.in_valid && bus.ex_load && bus.ex_wr && (bus.ex_dest != REG_PC) &&
                 ((bus.use_a && (bus.SA == bus.ex_dest)) ||
                  (bus.use_b && (bus.SB == bus.ex_dest)));
    end

    assign bus.stall_req = hazard && !bus.flush;

    // Bubbles keep the datapath fields so only control toggles.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            op_a_q <= '0;
            op_b_q <= '0;
            dsel_q <= '0;
            ctrl_q <= CTRL_BUBBLE;
        end else if (bus.flush || hazard) begin
            ctrl_q <= CTRL_BUBBLE;
        end else begin
            op_a_q <= sel_a;
            op_b_q <= sel_b;
            dsel_q <= bus.dsel_in;
            ctrl_q <= '{valid: bus.in_valid, wr: bus.wr_in, load: bus.load_in};
        end
    end

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.dsel_out  = dsel_q;
    assign bus.wr_out    = ctrl_q.wr;
    assign bus.load_out  = ctrl_q.load;
    assign bus.out_valid = ctrl_q.valid;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios followed by randomized traffic,
// checked against a behavioural model of the stage's selection and stall rules.
module tb_operand_fetch_stage;

    logic CLK;
    logic CLR;
    int   n_cmp;
    int   n_fail;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model of the registered outputs.
    logic [31:0] m_op_a;
    logic [31:0] m_op_b;
    logic [3:0]  m_dsel;
    logic        m_wr;
    logic        m_load;
    logic        m_valid;

    function automatic logic [31:0] ref_operand(input logic [3:0] sel, input logic [31:0] rf);
        if (sel == 4'd15)                                    return bus.pc_plus8;
        if (bus.ex_wr && bus.ex_dest == sel && !bus.ex_load) return bus.ex_result;
        if (bus.mem_wr && bus.mem_dest == sel)               return bus.mem_result;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        logic reads_load;
        reads_load = (bus.use_a && bus.SA == bus.ex_dest) || (bus.use_b && bus.SB == bus.ex_dest);
        return bus.in_valid && bus.ex_load && bus.ex_wr && reads_load && (bus.ex_dest != 4'd15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_op_a = '0; m_op_b = '0; m_dsel = '0;
        m_wr = 1'b0; m_load = 1'b0; m_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".op_a"},      bus.op_a,      m_op_a);
        chk({tag, ".op_b"},      bus.op_b,      m_op_b);
        chk({tag, ".dsel_out"},  bus.dsel_out,  32'(m_dsel));
        chk({tag, ".wr_out"},    bus.wr_out,    32'(m_wr));
        chk({tag, ".load_out"},  bus.load_out,  32'(m_load));
        chk({tag, ".out_valid"}, bus.out_valid, 32'(m_valid));
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.PA = '0; bus.PB = '0; bus.SA = '0; bus.SB = '0;
        bus.use_a = 0; bus.use_b = 0; bus.dsel_in = '0; bus.wr_in = 0; bus.load_in = 0;
        bus.pc_plus8 = '0; bus.ex_result = '0; bus.mem_result = '0;
        bus.ex_dest = '0; bus.mem_dest = '0; bus.ex_wr = 0; bus.mem_wr = 0;
        bus.ex_load = 0; bus.flush = 0;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step(input string tag);
        logic haz;
        #1;
        haz = ref_hazard();
        chk({tag, ".stall_req"}, bus.stall_req, 32'(haz && !bus.flush));
        if (bus.flush || haz) begin
            m_valid = 0; m_wr = 0; m_load = 0;
        end else begin
            m_op_a  = ref_operand(bus.SA, bus.PA);
            m_op_b  = ref_operand(bus.SB, bus.PB);
            m_dsel  = bus.dsel_in;
            m_wr    = bus.wr_in;
            m_load  = bus.load_in;
            m_valid = bus.in_valid;
        end
        @(posedge CLK);
        #1;
        check_outputs(tag);
        @(negedge CLK);
    endtask

    function automatic logic [3:0] rand_sel();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r + 8);
    endfunction

    initial begin
        n_cmp = 0;
        n_fail = 0;
        idle_inputs();
        CLR = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset.stall_req", bus.stall_req, 32'd0);
        @(negedge CLK);
        CLR = 1'b1;

        // No hazard: plain register-file read.
        bus.in_valid = 1; bus.SA = 4'd5; bus.PA = 32'h307; bus.use_a = 1;
        bus.SB = 4'd6; bus.PB = 32'hABCD; bus.use_b = 1;
        bus.dsel_in = 4'd2; bus.wr_in = 1; bus.ex_dest = 4'd9; bus.mem_dest = 4'd10;
        step("nohaz");
        chk("nohaz.op_a_const", bus.op_a, 32'h307);

        // EX beats MEM on the same register; MEM wins when EX is not writing.
        bus.SA = 4'd4; bus.ex_dest = 4'd4; bus.ex_wr = 1; bus.ex_result = 32'h1400_0006;
        bus.mem_dest = 4'd4; bus.mem_wr = 1; bus.mem_result = 32'hFFFF_FFFF;
        step("fwd_ex");
        chk("fwd_ex.op_a_const", bus.op_a, 32'h1400_0006);
        bus.ex_wr = 0;
        step("fwd_mem");
        chk("fwd_mem.op_a_const", bus.op_a, 32'hFFFF_FFFF);

        // R15 returns pc_plus8 even with a matching EX write.
        bus.mem_wr = 0;
        bus.SB = 4'd15; bus.pc_plus8 = 32'h108; bus.ex_dest = 4'd15; bus.ex_wr = 1;
        bus.ex_result = 32'h5555_0000;
        step("r15");
        chk("r15.op_b_const", bus.op_b, 32'h108);

        // Load-use: one bubble, then the load is forwarded from MEM.
        bus.SB = 4'd1; bus.SA = 4'd11; bus.use_a = 1; bus.PA = 32'h0BAD_0BAD;
        bus.ex_load = 1; bus.ex_wr = 1; bus.ex_dest = 4'd11; bus.dsel_in = 4'd3; bus.wr_in = 1;
        step("lu0");
        chk("lu0.out_valid_const", bus.out_valid, 32'd0);
        bus.ex_load = 0; bus.ex_wr = 0; bus.ex_dest = 4'd0;
        bus.mem_wr = 1; bus.mem_dest = 4'd11; bus.mem_result = 32'h1680_0005;
        step("lu1");
        chk("lu1.op_a_const", bus.op_a, 32'h1680_0005);
        chk("lu1.out_valid_const", bus.out_valid, 32'd1);

        // Unused operand never stalls.
        bus.mem_wr = 0; bus.use_a = 0; bus.use_b = 0;
        bus.ex_load = 1; bus.ex_wr = 1; bus.ex_dest = 4'd11;
        step("unused");

        // Flush during a hazard: no stall, bubble, then next instruction loads.
        bus.use_a = 1; bus.flush = 1;
        step("flush");
        bus.flush = 0; bus.ex_load = 0; bus.ex_wr = 0;
        bus.SA = 4'd7; bus.PA = 32'h7777_0007; bus.dsel_in = 4'd7; bus.load_in = 1;
        step("after_flush");

        // Asynchronous reset between edges, then a normal first load.
        #2 CLR = 1'b0;
        model_reset();
        #1;
        check_outputs("midreset");
        @(negedge CLK);
        CLR = 1'b1;
        bus.SA = 4'd2; bus.PA = 32'h2222_2222; bus.load_in = 0;
        step("post_reset");

        // Randomized traffic with a narrow register set so hazards and matches are frequent.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 7) != 0);
            bus.SA        = rand_sel();
            bus.SB        = rand_sel();
            bus.PA        = $urandom;
            bus.PB        = $urandom;
            bus.use_a     = $urandom_range(0, 1);
            bus.use_b     = $urandom_range(0, 1);
            bus.dsel_in   = 4'($urandom_range(0, 15));
            bus.wr_in     = $urandom_range(0, 1);
            bus.load_in   = $urandom_range(0, 1);
            bus.pc_plus8  = $urandom;
            bus.ex_result = $urandom;
            bus.mem_result = $urandom;
            bus.ex_dest   = rand_sel();
            bus.mem_dest  = rand_sel();
            bus.ex_wr     = $urandom_range(0, 1);
            bus.mem_wr    = $urandom_range(0, 1);
            bus.ex_load   = $urandom_range(0, 1);
            bus.flush     = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
